// File: rtl/softout_llr_pack_pkg.sv
`default_nettype none
// ============================================================================
// Package  : softout_llr_pack_pkg
// Purpose  : Shared constants and helpers for the soft-output LLR packer:
//            default soft/LLR widths, lane count and the symmetric LLR
//            saturation limit.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package softout_llr_pack_pkg;

   localparam int DEF_SOFT_W  = 31;
   localparam int DEF_LLR_W   = 8;
   localparam int NUM_LANES   = 4;

   // Symmetric limit: the most-negative two's-complement code is never used,
   // so +LIM and -LIM are the only clip values.
   localparam int DEF_LLR_MAX = (1 << (DEF_LLR_W - 1)) - 1;
   localparam int DEF_LLR_MIN = -DEF_LLR_MAX;

   function automatic int llr_max(input int llr_w);
      return (1 << (llr_w - 1)) - 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/softout_llr_pack_fifo.sv
`default_nettype none
// ============================================================================
// Module   : softout_llr_pack_fifo
// Purpose  : Synchronous single-clock FIFO holding quantised beats. The head
//            entry is presented combinationally from storage.
// Ports    : clk, rst (sync, active-low)
//            wr_en_i / wdata_i   - write port (never asserted when full)
//            rd_en_i / rdata_o   - read port, rdata_o is the current head
//            count_o             - number of stored entries (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module softout_llr_pack_fifo #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     rd_en_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q;
   logic [AW-1:0]    rptr_q;
   logic [AW:0]      count_q;

   // Storage is not reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (wr_en_i) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (rd_en_i) begin
            rptr_q <= rptr_q + 1'b1;
         end
         case ({wr_en_i, rd_en_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/softout_llr_pack.sv
`default_nettype none
// ============================================================================
// Module   : softout_llr_pack
// Purpose  : Rounds, scales and saturates four signed soft outputs per beat to
//            LLR_W-bit symmetric LLRs with hard decision and saturation flags,
//            buffers them in a small FIFO and delivers them over valid/ready
//            with an end-of-frame marker.
// Ports    : clk, rst (sync, active-low)
//            in_valid/in_ready, soft_out1..soft_out4  - input beat
//            out_valid/out_ready                      - output handshake
//            out_llr[4*LLR_W], out_hard[4], out_sat[4] - head beat lanes
//            out_last                                 - head is last of frame
// Revision : 1.0 - initial release
// ============================================================================
module softout_llr_pack
   import softout_llr_pack_pkg::*;
#(
   parameter int SOFT_W      = DEF_SOFT_W,
   parameter int LLR_W       = DEF_LLR_W,
   parameter int SHIFT       = 10,
   parameter int DEPTH       = 4,
   parameter int FRAME_BEATS = 256
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [SOFT_W-1:0]     soft_out1,
   input  logic signed [SOFT_W-1:0]     soft_out2,
   input  logic signed [SOFT_W-1:0]     soft_out3,
   input  logic signed [SOFT_W-1:0]     soft_out4,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NUM_LANES*LLR_W-1:0]   out_llr,
   output logic [NUM_LANES-1:0]         out_hard,
   output logic [NUM_LANES-1:0]         out_sat,
   output logic                         out_last
);

   localparam int YW  = SOFT_W + 1;
   localparam int LW  = NUM_LANES * LLR_W;
   localparam int FW  = LW + 2 * NUM_LANES;
   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int FCW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
   localparam int LIM = llr_max(LLR_W);

   localparam logic signed [YW-1:0] RND     = YW'(1) << (SHIFT - 1);
   localparam logic signed [YW-1:0] POS_LIM = YW'(LIM);
   localparam logic signed [YW-1:0] NEG_LIM = -POS_LIM;

   logic signed [SOFT_W-1:0] x [NUM_LANES];
   assign x[0] = soft_out1;
   assign x[1] = soft_out2;
   assign x[2] = soft_out3;
   assign x[3] = soft_out4;

   logic accept;
   assign accept = in_valid && in_ready;

   // ---------------- stage 1: round half-up and arithmetic shift ----------
   logic signed [YW-1:0] s1_y_d [NUM_LANES];
   logic signed [YW-1:0] s1_y_q [NUM_LANES];
   logic [NUM_LANES-1:0] s1_hard_d;
   logic [NUM_LANES-1:0] s1_hard_q;
   logic                 s1_valid_q;

   // One extra bit of headroom keeps x + 2^(SHIFT-1) from overflowing.
   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         s1_y_d[i]    = ($signed({x[i][SOFT_W-1], x[i]}) + RND) >>> SHIFT;
         s1_hard_d[i] = x[i][SOFT_W-1];
      end
   end

   // ---------------- stage 2: symmetric saturation ------------------------
   logic [LW-1:0]        s2_llr_d;
   logic [NUM_LANES-1:0] s2_sat_d;
   logic [LW-1:0]        s2_llr_q;
   logic [NUM_LANES-1:0] s2_sat_q;
   logic [NUM_LANES-1:0] s2_hard_q;
   logic                 s2_valid_q;

   always_comb begin
      s2_llr_d = '0;
      s2_sat_d = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (s1_y_q[i] > POS_LIM) begin
            s2_llr_d[i*LLR_W +: LLR_W] = POS_LIM[LLR_W-1:0];
            s2_sat_d[i]                = 1'b1;
         end else if (s1_y_q[i] < NEG_LIM) begin
            s2_llr_d[i*LLR_W +: LLR_W] = NEG_LIM[LLR_W-1:0];
            s2_sat_d[i]                = 1'b1;
         end else begin
            s2_llr_d[i*LLR_W +: LLR_W] = s1_y_q[i][LLR_W-1:0];
         end
      end
   end

   // Pipeline never stalls: in_ready reserves FIFO room for in-flight beats.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
         s1_hard_q  <= '0;
         for (int i = 0; i < NUM_LANES; i++) begin
            s1_y_q[i] <= '0;
         end
         s2_valid_q <= 1'b0;
         s2_llr_q   <= '0;
         s2_sat_q   <= '0;
         s2_hard_q  <= '0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_hard_q <= s1_hard_d;
            for (int i = 0; i < NUM_LANES; i++) begin
               s1_y_q[i] <= s1_y_d[i];
            end
         end
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_llr_q  <= s2_llr_d;
            s2_sat_q  <= s2_sat_d;
            s2_hard_q <= s1_hard_q;
         end
      end
   end

   // ---------------- output FIFO ------------------------------------------
   logic [FW-1:0] fifo_rdata;
   logic [CW-1:0] fifo_count;
   logic          xfer;

   assign out_valid = (fifo_count != '0);
   assign xfer      = out_valid && out_ready;

   softout_llr_pack_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en_i (s2_valid_q),
      .wdata_i ({s2_sat_q, s2_hard_q, s2_llr_q}),
      .rd_en_i (xfer),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count)
   );

   // Head storage is not reset, so outputs are forced to zero when empty.
   assign out_llr  = out_valid ? fifo_rdata[LW-1:0]                       : '0;
   assign out_hard = out_valid ? fifo_rdata[LW +: NUM_LANES]              : '0;
   assign out_sat  = out_valid ? fifo_rdata[LW+NUM_LANES +: NUM_LANES]    : '0;

   assign in_ready = rst &&
                     ((int'(fifo_count) + int'(s1_valid_q) + int'(s2_valid_q)) < DEPTH);

   // ---------------- output-side frame counter ----------------------------
   logic [FCW-1:0] fcnt_q;
   logic           at_last;

   assign at_last  = (fcnt_q == FCW'(FRAME_BEATS - 1));
   assign out_last = out_valid && at_last;

   always_ff @(posedge clk) begin
      if (!rst) begin
         fcnt_q <= '0;
      end else if (xfer) begin
         fcnt_q <= at_last ? '0 : fcnt_q + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_softout_llr_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_softout_llr_pack
// Purpose  : Self-checking bench for softout_llr_pack. Accepted beats are
//            quantised by an arithmetic reference model and queued; a monitor
//            pops and compares every transferred output beat, including the
//            expected end-of-frame marker.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_softout_llr_pack;

   localparam int SOFT_W = 31;
   localparam int LLR_W  = 8;
   localparam int SHIFT  = 10;
   localparam int DEPTH  = 4;
   localparam int FB     = 8;
   localparam int LIM    = (1 << (LLR_W - 1)) - 1;

   logic                     clk = 1'b0;
   logic                     rst = 1'b0;
   logic                     in_valid = 1'b0;
   logic                     in_ready;
   logic signed [SOFT_W-1:0] x1 = '0, x2 = '0, x3 = '0, x4 = '0;
   logic                     out_valid;
   logic                     out_ready = 1'b0;
   logic [4*LLR_W-1:0]       out_llr;
   logic [3:0]               out_hard;
   logic [3:0]               out_sat;
   logic                     out_last;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4*LLR_W-1:0] llr;
      logic [3:0]         hard;
      logic [3:0]         sat;
   } exp_t;

   exp_t sb[$];
   int   xfer_cnt = 0;

   softout_llr_pack #(
      .SOFT_W      (SOFT_W),
      .LLR_W       (LLR_W),
      .SHIFT       (SHIFT),
      .DEPTH       (DEPTH),
      .FRAME_BEATS (FB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .soft_out1 (x1),
      .soft_out2 (x2),
      .soft_out3 (x3),
      .soft_out4 (x4),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_llr   (out_llr),
      .out_hard  (out_hard),
      .out_sat   (out_sat),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: floor((x + 2^(SHIFT-1)) / 2^SHIFT), then clip to +-LIM.
   function automatic exp_t model(input logic signed [SOFT_W-1:0] a, b, c, d);
      exp_t   e;
      longint xs [4];
      longint v, q, div;
      xs[0] = longint'(a);
      xs[1] = longint'(b);
      xs[2] = longint'(c);
      xs[3] = longint'(d);
      div = longint'(1) << SHIFT;
      e.llr  = '0;
      e.hard = '0;
      e.sat  = '0;
      for (int i = 0; i < 4; i++) begin
         v = xs[i] + (div / 2);
         if (v >= 0) q = v / div;
         else        q = -((-v + div - 1) / div);
         if (q > LIM) begin
            q = LIM;
            e.sat[i] = 1'b1;
         end else if (q < -LIM) begin
            q = -LIM;
            e.sat[i] = 1'b1;
         end
         e.llr[i*LLR_W +: LLR_W] = q[LLR_W-1:0];
         e.hard[i] = (xs[i] < 0);
      end
      return e;
   endfunction

   function automatic logic signed [SOFT_W-1:0] rnd_soft();
      int s;
      logic [31:0] r;
      case ($urandom_range(0, 4))
         0: begin r = $urandom; return r[SOFT_W-1:0]; end
         1: s = int'($urandom_range(0, 400000)) - 200000;
         2: s = 130560 + int'($urandom_range(0, 2048)) - 1024;
         3: s = -130560 + int'($urandom_range(0, 2048)) - 1024;
         default: s = int'($urandom_range(0, 4096)) - 2048;
      endcase
      return SOFT_W'(s);
   endfunction

   task automatic drive_rand();
      x1 = rnd_soft();
      x2 = rnd_soft();
      x3 = rnd_soft();
      x4 = rnd_soft();
   endtask

   // Scoreboard producer: record the expected result of every accepted beat.
   always @(negedge clk) begin
      if (rst && in_valid && in_ready) begin
         sb.push_back(model(x1, x2, x3, x4));
      end
   end

   // Monitor: compare every transferred output beat against the queue head.
   always @(negedge clk) begin
      exp_t e;
      logic explast;
      if (!rst) begin
         sb.delete();
         xfer_cnt = 0;
      end else if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_unexpected: got beat llr=%h with no expected beat queued", out_llr);
         end else begin
            e = sb.pop_front();
            explast = ((xfer_cnt % FB) == FB - 1);
            chk("mon_beat", {23'd0, out_llr, out_hard, out_sat, out_last},
                {23'd0, e.llr, e.hard, e.sat, explast});
         end
         xfer_cnt++;
      end
   end

   task automatic directed(input int a, b, c, d, input logic [31:0] el,
                           input logic [3:0] eh, es, input string nm);
      @(posedge clk); #1;
      x1 = SOFT_W'(a); x2 = SOFT_W'(b); x3 = SOFT_W'(c); x4 = SOFT_W'(d);
      in_valid = 1'b1;
      @(negedge clk);
      chk({nm, "_in_ready"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk({nm, "_lat0"}, out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_lat1"}, out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_lat2_valid"}, out_valid, 1);
      chk({nm, "_llr"}, out_llr, el);
      chk({nm, "_hard"}, out_hard, eh);
      chk({nm, "_sat"}, out_sat, es);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      int  acc;
      int  cyc;
      logic stale;

      // ---- reset state ----
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_outputs", {out_llr, out_hard, out_sat, out_last}, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("in_ready_after_rst", in_ready, 1);

      // ---- directed beats ----
      directed(40000, -40000, 0, 512, 32'h0100D927, 4'b0010, 4'b0000, "beatA");
      directed(200000, -200000, 511, -512, 32'h0000817F, 4'b1010, 4'b0011, "beatB");

      // ---- back-pressure: exactly DEPTH beats accepted ----
      @(posedge clk); #1;
      out_ready = 1'b0;
      acc = 0;
      repeat (12) begin
         drive_rand();
         in_valid = 1'b1;
         @(negedge clk);
         if (in_ready) acc++;
         @(posedge clk); #1;
      end
      chk("bp_accepted", acc, DEPTH);
      @(negedge clk);
      chk("bp_in_ready_low", in_ready, 0);

      // ---- release and stream at full rate ----
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (8) begin
         drive_rand();
         @(posedge clk); #1;
      end
      acc = 0;
      repeat (16) begin
         drive_rand();
         @(negedge clk);
         if (in_ready) acc++;
         @(posedge clk); #1;
      end
      chk("stream_throughput", acc, 16);

      // ---- reset with beats in pipeline and FIFO ----
      in_valid = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      acc = 0;
      repeat (4) begin
         drive_rand();
         in_valid = 1'b1;
         @(negedge clk);
         if (in_ready) acc++;
         @(posedge clk); #1;
      end
      chk("midrst_fill", acc, 4);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      rst       = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", in_ready, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 0);
      stale = 1'b0;
      repeat (4) begin
         @(negedge clk);
         stale = stale | out_valid;
      end
      chk("midrst_no_stale", stale, 0);

      // ---- randomized traffic with random back-pressure ----
      @(posedge clk); #1;
      acc = 0;
      cyc = 0;
      while (acc < 10000 && cyc < 60000) begin
         drive_rand();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (in_valid && in_ready) acc++;
         @(posedge clk); #1;
         cyc++;
      end
      chk("rand_beats", acc, 10000);

      // ---- drain ----
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cyc = 0;
      while ((sb.size() != 0 || out_valid) && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      @(negedge clk);
      chk("drain_queue_empty", sb.size(), 0);
      chk("drain_out_valid", out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
